fp_addsub_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754 floating-point adder/subtractor with valid/ready flow control. Supports binary32 (EXP_W=8, MAN_W=23) and binary64 (EXP_W=11, MAN_W=52) from one RTL source. Rounding is round-to-nearest-even with exception flags. Sits in the FP datapath as the add unit feeding the FP result bus; accepts one operation per cycle.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_lzc.sv | 23 ++
 rtl/fp_addsub_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_pkg
// Brief  : Shared types, flag indices and operand classification for the
//          pipelined IEEE-754 adder/subtractor.
// Rev    : 1.0  initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    localparam int c_FLAG_INVALID   = 3;
    localparam int c_FLAG_OVERFLOW  = 2;
    localparam int c_FLAG_UNDERFLOW = 1;
    localparam int c_FLAG_INEXACT   = 0;

    // Control part shared by every stage payload; the datapath part is sized in the module
    typedef struct packed {
        logic       valid;
        logic       special;
        logic [3:0] flags;
    } fp_ctl_t;

    // Subnormals (exp==0, man!=0) classify as ZERO: inputs are flushed to zero
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero, input logic man_msb);
        if (exp_zero)  return ZERO;
        if (!exp_ones) return NORM;
        if (man_zero)  return INF;
        if (man_msb)   return QNAN;
        return SNAN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module : fp_lzc
// Brief  : Parametrised leading-zero counter; an all-zero input returns WIDTH.
// Rev    : 1.0  initial release
// ============================================================================
module fp_lzc #(
    parameter  int WIDTH = 27,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module : fp_addsub_pipe
// Brief  : Four-stage IEEE-754 adder/subtractor, RNE rounding, FTZ, with
//          valid/ready flow control (whole pipe stalls together).
// Rev    : 1.0  initial release
// ============================================================================
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int N     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int SW  = MAN_W + 4;           // hidden + fraction + guard/round/sticky
    localparam int EW  = EXP_W + 2;           // signed exponent headroom for normalisation
    localparam int LZW = $clog2(SW + 1);
    localparam logic [EXP_W-1:0]       c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic signed [EW-1:0]   c_EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [N-1:0]           c_QNAN     = {1'b0, c_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        fp_ctl_t          ctl;
        logic [N-1:0]     spec_res;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig_x;
        logic [MAN_W:0]   sig_y;
        logic [EXP_W-1:0] diff;
    } s1_t;

    typedef struct packed {
        fp_ctl_t          ctl;
        logic [N-1:0]     spec_res;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    x_al;
        logic [SW-1:0]    y_al;
    } s2_t;

    typedef struct packed {
        fp_ctl_t          ctl;
        logic [N-1:0]     spec_res;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW:0]      sum;
    } s3_t;

    s1_t r_s1, w_s1;
    s2_t r_s2, w_s2;
    s3_t r_s3, w_s3;
    logic w_adv;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // ---------------- S1: unpack, classify, resolve specials, swap ----------------
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_sa, w_sb;
    fp_class_e        w_ca, w_cb;

    assign w_sa = a[N-1];
    assign w_sb = b[N-1] ^ sub;
    assign w_ea = a[N-2:MAN_W];
    assign w_eb = b[N-2:MAN_W];
    assign w_ma = a[MAN_W-1:0];
    assign w_mb = b[MAN_W-1:0];
    assign w_ca = fp_classify(w_ea == '0, w_ea == c_EXP_ONES, w_ma == '0, w_ma[MAN_W-1]);
    assign w_cb = fp_classify(w_eb == '0, w_eb == c_EXP_ONES, w_mb == '0, w_mb[MAN_W-1]);

    always_comb begin
        w_s1           = '0;
        w_s1.ctl.valid = in_valid;
        w_s1.eff_sub   = w_sa ^ w_sb;
        if (a[N-2:0] >= b[N-2:0]) begin
            w_s1.sign  = w_sa;
            w_s1.exp   = w_ea;
            w_s1.sig_x = {1'b1, w_ma};
            w_s1.sig_y = {1'b1, w_mb};
            w_s1.diff  = w_ea - w_eb;
        end else begin
            w_s1.sign  = w_sb;
            w_s1.exp   = w_eb;
            w_s1.sig_x = {1'b1, w_mb};
            w_s1.sig_y = {1'b1, w_ma};
            w_s1.diff  = w_eb - w_ea;
        end
        w_s1.ctl.special = 1'b1;
        if (w_ca inside {QNAN, SNAN} || w_cb inside {QNAN, SNAN}) begin
            w_s1.spec_res                    = c_QNAN;
            w_s1.ctl.flags[c_FLAG_INVALID]   = (w_ca == SNAN) || (w_cb == SNAN);
        end else if (w_ca == INF && w_cb == INF) begin
            if (w_sa != w_sb) begin
                w_s1.spec_res                  = c_QNAN;
                w_s1.ctl.flags[c_FLAG_INVALID] = 1'b1;
            end else begin
                w_s1.spec_res = {w_sa, c_EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (w_ca == INF) begin
            w_s1.spec_res = {w_sa, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_cb == INF) begin
            w_s1.spec_res = {w_sb, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_ca == ZERO && w_cb == ZERO) begin
            w_s1.spec_res = {w_sa & w_sb, {(N-1){1'b0}}};
        end else if (w_ca == ZERO) begin
            w_s1.spec_res = {w_sb, b[N-2:0]};
        end else if (w_cb == ZERO) begin
            w_s1.spec_res = a;
        end else begin
            w_s1.ctl.special = 1'b0;
        end
    end

    // ---------------- S2: align Y to X ----------------
    logic [SW-1:0] w_y_full, w_y_sh, w_mask;
    logic          w_sticky;

    assign w_y_full = {r_s1.sig_y, 3'b000};
    assign w_y_sh   = w_y_full >> r_s1.diff;
    assign w_mask   = ~({SW{1'b1}} << r_s1.diff);
    assign w_sticky = |(w_y_full & w_mask);

    always_comb begin
        w_s2          = '0;
        w_s2.ctl      = r_s1.ctl;
        w_s2.spec_res = r_s1.spec_res;
        w_s2.sign     = r_s1.sign;
        w_s2.eff_sub  = r_s1.eff_sub;
        w_s2.exp      = r_s1.exp;
        w_s2.x_al     = {r_s1.sig_x, 3'b000};
        if (32'(r_s1.diff) >= 32'(MAN_W + 3)) begin
            w_s2.y_al = {{(SW-1){1'b0}}, 1'b1};
        end else begin
            w_s2.y_al = {w_y_sh[SW-1:1], w_y_sh[0] | w_sticky};
        end
    end

    // ---------------- S3: magnitude add / subtract (X >= Y, never negative) ----------------
    always_comb begin
        w_s3          = '0;
        w_s3.ctl      = r_s2.ctl;
        w_s3.spec_res = r_s2.spec_res;
        w_s3.sign     = r_s2.sign;
        w_s3.exp      = r_s2.exp;
        w_s3.sum      = r_s2.eff_sub ? ({1'b0, r_s2.x_al} - {1'b0, r_s2.y_al})
                                     : ({1'b0, r_s2.x_al} + {1'b0, r_s2.y_al});
    end

    // ---------------- S4: normalise, round, pack ----------------
    logic [LZW-1:0]        w_lz;
    logic [SW-1:0]         w_norm;
    logic signed [EW-1:0]  w_exp_n, w_exp_r;
    logic [MAN_W+1:0]      w_rnd;
    logic [MAN_W-1:0]      w_frac;
    logic                  w_rup, w_inexact;
    logic [N-1:0]          w_res;
    logic [3:0]            w_flags;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .i_vec   (r_s3.sum[SW-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        if (r_s3.sum[SW]) begin
            w_norm  = {r_s3.sum[SW:2], r_s3.sum[1] | r_s3.sum[0]};
            w_exp_n = $signed({2'b00, r_s3.exp}) + EW'(1);
        end else begin
            w_norm  = r_s3.sum[SW-1:0] << w_lz;
            w_exp_n = $signed({2'b00, r_s3.exp}) - $signed({{(EW-LZW){1'b0}}, w_lz});
        end
        w_inexact = |w_norm[2:0];
        w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd     = {1'b0, w_norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
        // Rounding carry out of the significand bumps the exponent once more
        w_exp_r   = w_exp_n + (w_rnd[MAN_W+1] ? EW'(1) : EW'(0));
        w_frac    = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

        w_res   = {r_s3.sign, w_exp_r[EXP_W-1:0], w_frac};
        w_flags = {3'b000, w_inexact};
        if (r_s3.ctl.special) begin
            w_res   = r_s3.spec_res;
            w_flags = r_s3.ctl.flags;
        end else if (r_s3.sum == '0) begin
            w_res   = '0;
            w_flags = '0;
        end else if (w_exp_r >= c_EXP_MAX) begin
            w_res                     = {r_s3.sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_flags                   = '0;
            w_flags[c_FLAG_OVERFLOW]  = 1'b1;
            w_flags[c_FLAG_INEXACT]   = 1'b1;
        end else if (w_exp_r[EW-1] || w_exp_r == '0) begin
            w_res                     = {r_s3.sign, {(N-1){1'b0}}};
            w_flags                   = '0;
            w_flags[c_FLAG_UNDERFLOW] = 1'b1;
            w_flags[c_FLAG_INEXACT]   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_adv) begin
            r_s1      <= w_s1;
            r_s2      <= w_s2;
            r_s3      <= w_s3;
            out_valid <= r_s3.ctl.valid;
            result    <= w_res;
            flags     <= w_flags;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_addsub_pipe
// Brief  : Scoreboard bench for fp_addsub_pipe (binary32 and binary64 builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    logic        in_valid_d, in_ready_d, sub_d, out_valid_d, out_ready_d;
    logic [63:0] a_d, b_d, result_d;
    logic [3:0]  flags_d;

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .a(a_d), .b(b_d), .sub(sub_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
        .result(result_d), .flags(flags_d)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int NV = 20;
    localparam vec_t VECS [NV] = '{
        '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0},
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1},
        '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8},
        '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0},
        '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0},
        '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0},
        '{32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 4'h0},
        '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 4'h0},
        '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0},
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3},
        '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0},
        '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'h0},
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8}
    };

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_out = 0;
    bit          saw_stall = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_res;
    logic [3:0]  prev_flg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Exact binary32 encoding of a small integer (|v| < 2^24)
    function automatic logic [31:0] int2f(input int v);
        int          m;
        int          p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if (m >= (1 << i)) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007FFFFF);
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: compare on the handshake, check stability while stalled
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (!in_ready) saw_stall = 1;
            if (out_valid) begin
                if (prev_hold) begin
                    check("hold_res", result, prev_res);
                    check("hold_flg", flags, prev_flg);
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_out", out_valid, 1'b0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        n_out++;
                        check($sformatf("res#%0d", n_out), result, mon_e.res);
                        check($sformatf("flg#%0d", n_out), flags, mon_e.flg);
                        if (mon_e.lat) check($sformatf("lat#%0d", n_out), cyc - mon_e.acc_cyc, 4);
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = result;
            prev_flg  = flags;
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [31:0] er, input logic [3:0] ef, input bit lat);
        exp_t e;
        int   w;
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.res = er; e.flg = ef; e.acc_cyc = cyc; e.lat = lat;
                sb_q.push_back(e);
                break;
            end
            w++;
            if (w > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic send64(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                          input logic [63:0] er, input string tag);
        int c0;
        int k;
        a_d = ta; b_d = tb; sub_d = ts; in_valid_d = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready_d, 1'b1);
        c0 = cyc;
        @(posedge clk); #1;
        in_valid_d = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (out_valid_d) break;
        end
        check({tag, "_lat"}, cyc - c0, 4);
        check({tag, "_res"}, result_d, er);
        check({tag, "_flg"}, flags_d, 4'h0);
        @(posedge clk); #1;
    endtask

    int n_before;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid_d = 1'b0; a_d = '0; b_d = '0; sub_d = 1'b0; out_ready_d = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_flags", flags, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid_d", out_valid_d, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, streamed back-to-back with no stalls
        for (int i = 0; i < NV; i++)
            send(VECS[i].a, VECS[i].b, VECS[i].s, VECS[i].r, VECS[i].f, 1'b1);
        drain();

        // Backpressure: 8 ops with out_ready held low for 5 cycles mid-stream
        n_before  = n_out;
        saw_stall = 0;
        fork
            for (int i = 0; i < 8; i++)
                send(int2f(10 * i + 5), int2f(i + 2), 1'(i % 2),
                     int2f((i % 2 == 1) ? (10 * i + 5) - (i + 2) : (10 * i + 5) + (i + 2)),
                     4'h0, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", saw_stall, 1'b1);
        check("bp_count", n_out - n_before, 8);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) send(int2f(i + 1), int2f(1), 1'b0, int2f(i + 2), 4'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        sb_q.delete();
        @(negedge clk);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_flags", flags, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_before = n_out;
        repeat (10) @(negedge clk);
        check("rst_no_stale", n_out - n_before, 0);
        @(posedge clk); #1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 1'b1);
        drain();

        // binary64 build
        send64(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, "d64_add");
        send64(64'h4008000000000000, 64'h3FF0000000000000, 1'b1, 64'h4000000000000000, "d64_sub");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
